// File: rtl/byte_ram.sv
// Byte-addressed RAM with big-endian word access, byte-lane write enables and a
// fixed request-to-response latency. One access in flight at a time.
module byte_ram #(
    parameter int DATA_BYTES = 4,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 32,
    parameter int LATENCY    = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    input  logic                    rw,
    input  logic [ADDR_W-1:0]       address,
    input  logic [DATA_BYTES-1:0]   byte_en,
    input  logic [8*DATA_BYTES-1:0] data_in,
    output logic                    ready,
    output logic [8*DATA_BYTES-1:0] data_out,
    output logic                    valid,
    output logic                    err
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         DW       = 8 * DATA_BYTES;
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;

    logic [ADDR_W-1:0]     addr_q;
    logic                  rw_q;
    logic [DATA_BYTES-1:0] be_q;
    logic [DW-1:0]         din_q;

    logic [7:0] ram [DEPTH];

    // With LATENCY=1 the edge entering RESP is the acceptance edge itself, so the
    // access fields come straight from the inputs; otherwise from the latches.
    logic [ADDR_W-1:0]     acc_addr;
    logic                  acc_rw;
    logic [DATA_BYTES-1:0] acc_be;
    logic [DW-1:0]         acc_din;
    logic [ADDR_W:0]       end_addr;
    logic                  acc_err;
    logic [IDX_W-1:0]      base;
    logic [DW-1:0]         rd_word;
    logic                  fire;
    logic                  wr_en;

    always_comb begin
        acc_addr = (state == IDLE) ? address : addr_q;
        acc_rw   = (state == IDLE) ? rw      : rw_q;
        acc_be   = (state == IDLE) ? byte_en : be_q;
        acc_din  = (state == IDLE) ? data_in : din_q;
        end_addr = {1'b0, acc_addr} + (ADDR_W+1)'(DATA_BYTES);
        acc_err  = ((acc_addr % ADDR_W'(DATA_BYTES)) != '0) ||
                   (end_addr > (ADDR_W+1)'(DEPTH));
        base     = acc_addr[IDX_W-1:0];
        fire     = ((state == IDLE) && req && (LATENCY == 1)) ||
                   ((state == WAIT) && (cnt == 4'd0));
        // Reset is asynchronous for the control state; keep the array quiet during it too.
        wr_en    = fire && rst_n && !acc_rw && !acc_err;
    end

    always_comb begin
        rd_word = '0;
        for (int j = 0; j < DATA_BYTES; j++)
            rd_word[8*j +: 8] = ram[base + IDX_W'(DATA_BYTES - 1 - j)];
    end

    // NOTE: storage arrays carry no reset; only control and output registers do.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < DATA_BYTES; j++)
                if (acc_be[j]) ram[base + IDX_W'(DATA_BYTES - 1 - j)] <= acc_din[8*j +: 8];
        end
    end

    // NOTE: every clocked block uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            be_q     <= '0;
            din_q    <= '0;
            data_out <= '0;
            err      <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if ((state == IDLE) && req) begin
                addr_q <= address;
                rw_q   <= rw;
                be_q   <= byte_en;
                din_q  <= data_in;
            end
            if (fire) begin
                err <= acc_err;
                if (acc_err)     data_out <= '0;
                else if (acc_rw) data_out <= rd_word;
            end
        end
    end

    // NOTE: combinational blocks assign defaults first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: if (req) begin
                if (LATENCY == 1) begin
                    state_nxt = RESP;
                end else begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_INIT;
                end
            end
            WAIT: if (cnt == 4'd0) state_nxt = RESP;
                  else             cnt_nxt   = cnt - 4'd1;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign ready = (state == IDLE);
    assign valid = (state == RESP);

endmodule

// File: tb/tb_byte_ram.sv
// Directed bench for byte_ram: three instances (defaults, LATENCY=3, 16-bit/16-byte)
// with a response scoreboard and immediate-assertion checks.
module tb_byte_ram;

    logic        clk = 1'b0;
    logic        rst_n_a, rst_n_b, rst_n_c;
    logic        req, rw;
    logic [31:0] address, din;
    logic [3:0]  be;
    int          sel;

    logic        ready_a, valid_a, err_a;
    logic        ready_b, valid_b, err_b;
    logic        ready_c, valid_c, err_c;
    logic [31:0] dout_a, dout_b;
    logic [15:0] dout_c;

    logic        o_ready, o_valid, o_err;
    logic [31:0] o_dout;

    int passes = 0;
    int total  = 0;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] dout;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    byte_ram u_a (
        .clk(clk), .rst_n(rst_n_a), .req(req && sel == 0), .rw(rw), .address(address),
        .byte_en(be), .data_in(din), .ready(ready_a), .data_out(dout_a),
        .valid(valid_a), .err(err_a)
    );

    byte_ram #(.LATENCY(3)) u_b (
        .clk(clk), .rst_n(rst_n_b), .req(req && sel == 1), .rw(rw), .address(address),
        .byte_en(be), .data_in(din), .ready(ready_b), .data_out(dout_b),
        .valid(valid_b), .err(err_b)
    );

    byte_ram #(.DATA_BYTES(2), .DEPTH(16)) u_c (
        .clk(clk), .rst_n(rst_n_c), .req(req && sel == 2), .rw(rw), .address(address),
        .byte_en(be[1:0]), .data_in(din[15:0]), .ready(ready_c), .data_out(dout_c),
        .valid(valid_c), .err(err_c)
    );

    always_comb begin
        o_ready = ready_a; o_valid = valid_a; o_err = err_a; o_dout = dout_a;
        case (sel)
            1: begin o_ready = ready_b; o_valid = valid_b; o_err = err_b; o_dout = dout_b; end
            2: begin o_ready = ready_c; o_valid = valid_c; o_err = err_c; o_dout = {16'h0, dout_c}; end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_idle(input int d, input string tag);
        sel = d;
        #1;
        check({tag, " ready"}, 32'(o_ready), 32'd1);
        check({tag, " valid"}, 32'(o_valid), 32'd0);
        check({tag, " err"},   32'(o_err),   32'd0);
        check({tag, " dout"},  o_dout,       32'd0);
    endtask

    // One request: push the expected response, drive, scramble inputs after
    // acceptance, then pop and compare when Valid appears.
    task automatic access(input int d, input string tag, input logic rw_i,
                          input logic [31:0] a, input logic [3:0] be_i, input logic [31:0] din_i,
                          input logic exp_err, input logic [31:0] exp_dout, input int exp_lat);
        exp_t e;
        int   got;
        e = '{tag, exp_err, exp_dout, exp_lat};
        sb.push_back(e);
        @(negedge clk);
        sel = d; rw = rw_i; address = a; be = be_i; din = din_i; req = 1'b1;
        #1;
        check({tag, " ready"}, 32'(o_ready), 32'd1);
        @(posedge clk);
        got = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 1'b0; address = ~a; din = ~din_i; be = ~be_i; rw = ~rw_i;
                #1;
            end
            if (o_valid) begin
                got = k;
                break;
            end
        end
        e = sb.pop_front();
        check({e.tag, " latency"}, 32'(got), 32'(e.lat));
        if (got != 0) begin
            check({e.tag, " err"},  32'(o_err), 32'(e.err));
            check({e.tag, " dout"}, o_dout,     e.dout);
            @(negedge clk);
            #1;
            check({e.tag, " valid drop"}, 32'(o_valid), 32'd0);
            check({e.tag, " ready back"}, 32'(o_ready), 32'd1);
        end
    endtask

    initial begin
        int seen;
        rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
        req = 1'b0; rw = 1'b0; address = '0; din = '0; be = '0; sel = 0;
        check_idle(0, "rst a");
        check_idle(1, "rst b");
        check_idle(2, "rst c");
        repeat (2) @(negedge clk);
        rst_n_a = 1'b1; rst_n_b = 1'b1; rst_n_c = 1'b1;

        // Default instance: full/partial writes, reads, error cases.
        access(0, "a wr full",   1'b0, 32'h08, 4'hF, 32'h11223344, 1'b0, 32'h0,        1);
        access(0, "a rd 08",     1'b1, 32'h08, 4'h0, 32'h0,        1'b0, 32'h11223344, 1);
        check("a ram08", 32'(u_a.ram[8]),  32'h11);
        check("a ram0b", 32'(u_a.ram[11]), 32'h44);
        access(0, "a wr part",   1'b0, 32'h08, 4'h5, 32'hAABBCCDD, 1'b0, 32'h11223344, 1);
        access(0, "a rd part",   1'b1, 32'h08, 4'h0, 32'h0,        1'b0, 32'h11BB33DD, 1);
        access(0, "a rd mis",    1'b1, 32'h06, 4'h0, 32'h0,        1'b1, 32'h0,        1);
        access(0, "a rd oor",    1'b1, 32'h40, 4'h0, 32'h0,        1'b1, 32'h0,        1);
        access(0, "a rd wrap",   1'b1, 32'hFFFFFFFC, 4'h0, 32'h0,  1'b1, 32'h0,        1);
        access(0, "a wr top",    1'b0, 32'h3C, 4'hF, 32'h01020304, 1'b0, 32'h0,        1);
        access(0, "a wr 3e err", 1'b0, 32'h3E, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0,        1);
        access(0, "a rd top",    1'b1, 32'h3C, 4'h0, 32'h0,        1'b0, 32'h01020304, 1);
        access(0, "a wr be0",    1'b0, 32'h08, 4'h0, 32'hFFFFFFFF, 1'b0, 32'h01020304, 1);
        access(0, "a rd be0",    1'b1, 32'h08, 4'h0, 32'h0,        1'b0, 32'h11BB33DD, 1);

        // LATENCY=3: Req held high, Ready 1,0,0,0 and Valid on the fourth cycle.
        @(negedge clk);
        sel = 1; rw = 1'b0; be = 4'h0; address = 32'h10; din = 32'h0; req = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("b pat ready %0d", i), 32'(o_ready), 32'((i % 4) == 0));
            check($sformatf("b pat valid %0d", i), 32'(o_valid), 32'((i % 4) == 3));
        end
        req = 1'b0;
        @(negedge clk);
        #1;
        check("b pat idle", 32'(o_ready), 32'd1);
        check("b pat dout", o_dout, 32'd0);

        access(1, "b wr",  1'b0, 32'h10, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        3);
        access(1, "b rd",  1'b1, 32'h10, 4'h0, 32'h0,        1'b0, 32'hCAFEF00D, 3);

        // LATENCY=3: reset pulsed during WAIT aborts the write.
        @(negedge clk);
        sel = 1; rw = 1'b0; address = 32'h10; be = 4'hF; din = 32'h12345678; req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #1;
        check("b abort in wait", 32'(o_ready), 32'd0);
        rst_n_b = 1'b0;
        #1;
        check("b abort ready", 32'(o_ready), 32'd1);
        check("b abort valid", 32'(o_valid), 32'd0);
        check("b abort dout",  o_dout,       32'd0);
        repeat (2) @(negedge clk);
        rst_n_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (o_valid) seen++;
        end
        check("b abort no resp", 32'(seen), 32'd0);
        check("b abort dout hold", o_dout, 32'd0);
        access(1, "b rd after abort", 1'b1, 32'h10, 4'h0, 32'h0, 1'b0, 32'hCAFEF00D, 3);

        // DATA_BYTES=2, DEPTH=16.
        access(2, "c wr top", 1'b0, 32'h0E, 4'h3, 32'h0000BEEF, 1'b0, 32'h0,    1);
        access(2, "c rd top", 1'b1, 32'h0E, 4'h0, 32'h0,        1'b0, 32'hBEEF, 1);
        access(2, "c rd mis", 1'b1, 32'h0F, 4'h0, 32'h0,        1'b1, 32'h0,    1);
        access(2, "c rd oor", 1'b1, 32'h10, 4'h0, 32'h0,        1'b1, 32'h0,    1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
